dbus_uncached_bridge: RTL and testbench
=======================================

# dbus_uncached_bridge

Converts single data-bus requests (dbus_req_t/dbus_resp_t) into single-beat cache-bus transactions (cbus_req_t/cbus_resp_t) for uncached address regions. The block sits between the CPU memory stage and the cbus arbiter, in parallel with the data cache; the CPU-side address decoder steers uncached requests here. It has one outstanding transaction, a three-state FSM and a registered response.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on posedge.
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- dreq  in  dbus_req_t (72)  CPU request: valid, size, addr, strobe, data.
- dresp  out  dbus_resp_t (34)  addr_ok, data_ok, data to CPU.
- creq  out  cbus_req_t (77)  cache-bus request: valid, is_write, size, addr, strobe, data, len.
- cresp  in  cbus_resp_t (34)  ready, last, data from bus.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE
  - dresp.addr_ok = dreq.valid (combinational).
  - On a clock edge with dreq.valid=1, latch size, addr, strobe and data into req_q, then go to BUSY.
  - dreq.valid=0: stay in IDLE.
- BUSY
  - creq.valid=1 with fields driven from req_q: is_write = |strobe_q, size = size_q, addr = addr_q unmodified, strobe = strobe_q, data = data_q, len = MLEN1.
  - All creq fields stay stable for the whole BUSY state.
  - On an edge with cresp.ready=1 and cresp.last=1, latch cresp.data into rdata_q, then go to DONE.
  - cresp.ready=1 with last=0 is a protocol violation: ignore it and stay in BUSY.
- DONE
  - dresp.data_ok=1 and dresp.data=rdata_q for exactly one cycle, then go to IDLE.
  - Writes also produce data_ok. Write data_ok carries the bus response data, and the CPU ignores it.
- addr_ok is 0 in BUSY and DONE. A request presented during those states is held by the CPU and accepted once the FSM returns to IDLE.
- Read requests carry strobe=0. The bridge never modifies strobe or performs byte-lane alignment; the CPU handles alignment.
- cresp is ignored outside BUSY.
- dreq contents are ignored outside IDLE; req_q is frozen.

## Timing
- Reset values (asynchronous, while resetn=0):
  - state=IDLE.
  - creq all zeros, so creq.valid=0.
  - dresp.data_ok=0 and dresp.data=0.
  - dresp.addr_ok follows dreq.valid, because the state is IDLE.
  - req_q=0 and rdata_q=0.
- Request accepted at edge T0, so creq.valid=1 from cycle T0+1.
- First cresp.ready&last at edge Tk, so data_ok=1 during cycle Tk+1 only. The minimum case (ready in the first BUSY cycle) gives data_ok 2 cycles after acceptance.
- Earliest next addr_ok is cycle Tk+2, so the back-to-back throughput is one transaction per 3 cycles minimum.
- Reset mid-transaction: creq.valid drops to 0 immediately (asynchronously), the transaction is abandoned and no data_ok is issued. The external bus is reset by the same resetn.
- No combinational path from cresp to dresp. The only combinational path is dreq.valid → dresp.addr_ok.

## Test plan
- **Single read.**
  - Stimulus: dreq valid, addr=0xBFD0_0004, size=MSIZE4, strobe=0. Bus returns ready&last with data 0x1234_5678 on the 3rd BUSY cycle.
  - Required: addr_ok in the request cycle; creq.valid=1, is_write=0, len=MLEN1 for exactly 3 cycles; data_ok=1 with data 0x1234_5678 for one cycle.
- **Single write.**
  - Stimulus: addr=0xBFD0_F000, strobe=0x3, data=0xDEAD_BEEF, size=MSIZE2. Bus acks immediately.
  - Required: creq.is_write=1, strobe=0x3, data=0xDEAD_BEEF; data_ok 2 cycles after acceptance.
- **Held request while busy.**
  - Stimulus: second request held valid from the cycle after acceptance.
  - Required: addr_ok stays 0 through BUSY and DONE; the second request is accepted in the cycle after data_ok; its creq fields match the second request, not the first.
- **Field stability.**
  - Stimulus: CPU changes dreq.addr and dreq.data during BUSY.
  - Required: creq.addr and creq.data remain equal to the latched values.
- **Spurious bus response.**
  - Stimulus: cresp.ready=1, last=1 while IDLE; cresp.ready=1, last=0 while BUSY.
  - Required: no state change and no data_ok in either case.
- **Reset mid-op.**
  - Stimulus: resetn driven low asynchronously in the 2nd BUSY cycle.
  - Required: creq.valid=0 immediately; after release, state=IDLE, no data_ok, and a new read completes normally.

Source files
------------

// File: rtl/dbus_uncached_bridge_if.sv
// Data-bus / cache-bus record types and the bundle that carries them between
// the CPU-side request port and the cbus arbiter.
package dbus_uncached_bridge_pkg;
  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;
  localparam mlen_t  MLEN1  = 4'd0;

  typedef struct packed {
    logic        valid;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

interface dbus_uncached_bridge_if;
  import dbus_uncached_bridge_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport slave  (input dreq, input cresp, output dresp, output creq);
  modport master (output dreq, output cresp, input dresp, input creq);
endinterface

// File: rtl/dbus_uncached_bridge.sv
// Single-outstanding bridge turning uncached dbus requests into one-beat cbus
// transactions; the response to the CPU is always taken from a register.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | addr_ok follows dreq.valid; a valid request is latched
//   BUSY    | creq driven from the latched request until ready & last
//   DONE    | one-cycle data_ok carrying the registered bus data
module dbus_uncached_bridge
  import dbus_uncached_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  dbus_uncached_bridge_if.slave bus_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  msize_t      r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_strobe;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_accept;
  logic        w_bus_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_size   <= '0;
      r_addr   <= '0;
      r_strobe <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_size   <= bus_if.dreq.size;
        r_addr   <= bus_if.dreq.addr;
        r_strobe <= bus_if.dreq.strobe;
        r_wdata  <= bus_if.dreq.data;
      end
      if (w_bus_done) r_rdata <= bus_if.cresp.data;
    end
  end

  // creq is zero outside BUSY so the arbiter sees a clean idle request
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_bus_done   = 1'b0;
    bus_if.dresp = '0;
    bus_if.creq  = '0;
    case (r_state)
      ST_IDLE: begin
        bus_if.dresp.addr_ok = bus_if.dreq.valid;
        if (bus_if.dreq.valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        bus_if.creq.valid    = 1'b1;
        bus_if.creq.is_write = |r_strobe;
        bus_if.creq.size     = r_size;
        bus_if.creq.addr     = r_addr;
        bus_if.creq.strobe   = r_strobe;
        bus_if.creq.data     = r_wdata;
        bus_if.creq.len      = MLEN1;
        // ready without last cannot end a single-beat transfer
        if (bus_if.cresp.ready && bus_if.cresp.last) begin
          w_bus_done  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        bus_if.dresp.data_ok = 1'b1;
        bus_if.dresp.data    = r_rdata;
        w_state_nxt          = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Vector table, directed corner sequences and a randomized run against a
// timestamp-based transaction model for dbus_uncached_bridge.
module tb_dbus_uncached_bridge;
  import dbus_uncached_bridge_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  dbus_uncached_bridge_if bus();

  dbus_uncached_bridge dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    int          ack_cyc;
    logic [31:0] rdata;
    logic        exp_write;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    bus.dreq  = {1'b1, v.size, v.addr, v.strobe, v.wdata};
    bus.cresp = '0;
    @(negedge clk);
    chk($sformatf("v%0d_addr_ok", idx), 128'(bus.dresp.addr_ok), 128'(1));
    chk($sformatf("v%0d_idle_valid", idx), 128'(bus.creq.valid), 128'(0));
    tick();
    for (int i = 1; i <= v.ack_cyc; i++) begin
      bus.dreq = {1'($urandom), 3'($urandom), 32'($urandom), 4'($urandom), 32'($urandom)};
      if (i == v.ack_cyc) bus.cresp = {1'b1, 1'b1, v.rdata};
      else                bus.cresp = {1'($urandom), 1'b0, 32'($urandom)};
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_valid", idx, i), 128'(bus.creq.valid), 128'(1));
      chk($sformatf("v%0d_c%0d_is_write", idx, i), 128'(bus.creq.is_write), 128'(v.exp_write));
      chk($sformatf("v%0d_c%0d_size", idx, i), 128'(bus.creq.size), 128'(v.size));
      chk($sformatf("v%0d_c%0d_addr", idx, i), 128'(bus.creq.addr), 128'(v.addr));
      chk($sformatf("v%0d_c%0d_strobe", idx, i), 128'(bus.creq.strobe), 128'(v.strobe));
      chk($sformatf("v%0d_c%0d_data", idx, i), 128'(bus.creq.data), 128'(v.wdata));
      chk($sformatf("v%0d_c%0d_len", idx, i), 128'(bus.creq.len), 128'(MLEN1));
      chk($sformatf("v%0d_c%0d_addr_ok", idx, i), 128'(bus.dresp.addr_ok), 128'(0));
      chk($sformatf("v%0d_c%0d_data_ok", idx, i), 128'(bus.dresp.data_ok), 128'(0));
      tick();
    end
    bus.cresp      = {1'b1, 1'b1, 32'($urandom)};
    bus.dreq.valid = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_data_ok", idx), 128'(bus.dresp.data_ok), 128'(1));
    chk($sformatf("v%0d_rdata", idx), 128'(bus.dresp.data), 128'(v.rdata));
    chk($sformatf("v%0d_done_valid", idx), 128'(bus.creq.valid), 128'(0));
    chk($sformatf("v%0d_done_addr_ok", idx), 128'(bus.dresp.addr_ok), 128'(0));
    tick();
    bus.dreq  = '0;
    bus.cresp = '0;
    @(negedge clk);
    chk($sformatf("v%0d_post_data_ok", idx), 128'(bus.dresp.data_ok), 128'(0));
    chk($sformatf("v%0d_post_valid", idx), 128'(bus.creq.valid), 128'(0));
    tick();
  endtask

  vec_t vecs[5];

  // model state for the randomized run: acceptance and ack cycle stamps
  bit          m_have;
  int          m_ack;
  dbus_req_t   m_req;
  logic [31:0] m_rdata;

  initial begin
    cbus_req_t  exp_creq;
    dbus_resp_t exp_dresp;
    bit         m_busy;
    bit         m_done;
    bit         m_idle;

    checks = 0;
    errors = 0;

    vecs[0] = '{MSIZE4, 32'hBFD0_0004, 4'h0, 32'h0,          3, 32'h1234_5678, 1'b0};
    vecs[1] = '{MSIZE2, 32'hBFD0_F000, 4'h3, 32'hDEAD_BEEF,  1, 32'hCAFE_0001, 1'b1};
    vecs[2] = '{MSIZE1, 32'hBFD0_0013, 4'h0, 32'h0,          1, 32'h0000_00A5, 1'b0};
    vecs[3] = '{MSIZE4, 32'hBFC0_1000, 4'hF, 32'h0102_0304,  5, 32'h55AA_55AA, 1'b1};
    vecs[4] = '{MSIZE1, 32'hA000_0001, 4'h2, 32'hFFFF_00FF,  2, 32'h0,         1'b1};

    // reset values
    resetn    = 1'b0;
    bus.dreq  = {1'b1, MSIZE4, 32'h1111_2222, 4'hF, 32'h3333_4444};
    bus.cresp = {1'b1, 1'b1, 32'hFFFF_FFFF};
    #3;
    chk("rst_addr_ok_follows", 128'(bus.dresp.addr_ok), 128'(1));
    chk("rst_creq_zero", 128'(bus.creq), 128'(0));
    chk("rst_data_ok", 128'(bus.dresp.data_ok), 128'(0));
    chk("rst_data", 128'(bus.dresp.data), 128'(0));
    @(posedge clk);
    @(negedge clk);
    bus.dreq.valid = 1'b0;
    #1;
    chk("rst_addr_ok_low", 128'(bus.dresp.addr_ok), 128'(0));
    chk("rst_creq_zero2", 128'(bus.creq), 128'(0));
    bus.cresp = '0;
    resetn    = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) do_txn(vecs[i], i);

    // held request while busy
    bus.dreq = {1'b1, MSIZE4, 32'h1000_0000, 4'h0, 32'h0};
    @(negedge clk);
    chk("hold_a_addr_ok", 128'(bus.dresp.addr_ok), 128'(1));
    tick();
    bus.dreq = {1'b1, MSIZE4, 32'h2000_0040, 4'hF, 32'h1122_3344};
    @(negedge clk);
    chk("hold_busy1_addr_ok", 128'(bus.dresp.addr_ok), 128'(0));
    tick();
    bus.cresp = {1'b1, 1'b1, 32'h0000_0077};
    @(negedge clk);
    chk("hold_busy2_addr_ok", 128'(bus.dresp.addr_ok), 128'(0));
    chk("hold_a_creq_addr", 128'(bus.creq.addr), 128'(32'h1000_0000));
    tick();
    bus.cresp = '0;
    @(negedge clk);
    chk("hold_done_data_ok", 128'(bus.dresp.data_ok), 128'(1));
    chk("hold_done_data", 128'(bus.dresp.data), 128'(32'h0000_0077));
    chk("hold_done_addr_ok", 128'(bus.dresp.addr_ok), 128'(0));
    tick();
    @(negedge clk);
    chk("hold_b_addr_ok", 128'(bus.dresp.addr_ok), 128'(1));
    chk("hold_b_data_ok_low", 128'(bus.dresp.data_ok), 128'(0));
    tick();
    bus.dreq  = '0;
    bus.cresp = {1'b1, 1'b1, 32'h0000_0088};
    @(negedge clk);
    chk("hold_b_creq_addr", 128'(bus.creq.addr), 128'(32'h2000_0040));
    chk("hold_b_is_write", 128'(bus.creq.is_write), 128'(1));
    chk("hold_b_creq_data", 128'(bus.creq.data), 128'(32'h1122_3344));
    tick();
    bus.cresp = '0;
    @(negedge clk);
    chk("hold_b_data_ok", 128'(bus.dresp.data_ok), 128'(1));
    tick();
    tick();

    // spurious responses: ready&last while idle, ready without last while busy
    bus.cresp = {1'b1, 1'b1, 32'h0000_0BAD};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("spur_idle%0d_data_ok", i), 128'(bus.dresp.data_ok), 128'(0));
      chk($sformatf("spur_idle%0d_valid", i), 128'(bus.creq.valid), 128'(0));
      tick();
    end
    bus.cresp = '0;
    bus.dreq  = {1'b1, MSIZE4, 32'hBFD0_0100, 4'h0, 32'h0};
    tick();
    bus.dreq  = '0;
    bus.cresp = {1'b1, 1'b0, 32'h0000_0BAD};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("spur_busy%0d_valid", i), 128'(bus.creq.valid), 128'(1));
      chk($sformatf("spur_busy%0d_data_ok", i), 128'(bus.dresp.data_ok), 128'(0));
      tick();
    end
    bus.cresp = {1'b1, 1'b1, 32'h0000_600D};
    tick();
    bus.cresp = '0;
    @(negedge clk);
    chk("spur_done_data_ok", 128'(bus.dresp.data_ok), 128'(1));
    chk("spur_done_data", 128'(bus.dresp.data), 128'(32'h0000_600D));
    tick();

    // reset in the second BUSY cycle
    bus.dreq = {1'b1, MSIZE4, 32'hBFD0_0200, 4'h0, 32'h0};
    tick();
    bus.dreq = '0;
    @(negedge clk);
    chk("rmid_busy1_valid", 128'(bus.creq.valid), 128'(1));
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("rmid_creq_drop", 128'(bus.creq), 128'(0));
    @(negedge clk);
    chk("rmid_data_ok", 128'(bus.dresp.data_ok), 128'(0));
    chk("rmid_addr_ok", 128'(bus.dresp.addr_ok), 128'(0));
    resetn = 1'b1;
    tick();
    bus.cresp = {1'b1, 1'b1, 32'h0000_0BAD};
    @(negedge clk);
    chk("rmid_post_data_ok", 128'(bus.dresp.data_ok), 128'(0));
    chk("rmid_post_valid", 128'(bus.creq.valid), 128'(0));
    tick();
    do_txn(vecs[0], 9);

    // randomized run against the transaction model
    m_have  = 1'b0;
    m_ack   = -1;
    m_req   = '0;
    m_rdata = '0;
    for (int c = 0; c < 400; c++) begin
      bus.dreq.valid  = ($urandom_range(0, 99) < 50);
      bus.dreq.size   = 3'($urandom_range(0, 3));
      bus.dreq.addr   = 32'($urandom);
      bus.dreq.strobe = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      bus.dreq.data   = 32'($urandom);
      bus.cresp.ready = ($urandom_range(0, 99) < 40);
      bus.cresp.last  = ($urandom_range(0, 99) < 70);
      bus.cresp.data  = 32'($urandom);

      m_busy = m_have && (m_ack < 0);
      m_done = m_have && (m_ack >= 0) && (c == m_ack + 1);
      m_idle = !m_busy && !m_done;

      exp_creq  = '0;
      exp_dresp = '0;
      exp_dresp.addr_ok = m_idle && bus.dreq.valid;
      if (m_busy) begin
        exp_creq.valid    = 1'b1;
        exp_creq.is_write = (m_req.strobe != 4'h0);
        exp_creq.size     = m_req.size;
        exp_creq.addr     = m_req.addr;
        exp_creq.strobe   = m_req.strobe;
        exp_creq.data     = m_req.data;
        exp_creq.len      = MLEN1;
      end
      if (m_done) begin
        exp_dresp.data_ok = 1'b1;
        exp_dresp.data    = m_rdata;
      end

      @(negedge clk);
      chk($sformatf("rnd%0d_creq", c), 128'(bus.creq), 128'(exp_creq));
      chk($sformatf("rnd%0d_dresp", c), 128'(bus.dresp), 128'(exp_dresp));

      if (m_idle && bus.dreq.valid) begin
        m_have = 1'b1;
        m_ack  = -1;
        m_req  = bus.dreq;
      end else if (m_busy && bus.cresp.ready && bus.cresp.last) begin
        m_ack   = c;
        m_rdata = bus.cresp.data;
      end else if (m_done) begin
        m_have = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
